// File: rtl/lock_pid_sequencer_if.sv
// Register-bank / PID-side signal bundle for one lock sequencer channel.
// The slave modport is the sequencer; the master modport is its environment.
interface lock_pid_sequencer_if #(
    parameter int CNTW = 16,
    parameter int RCW  = 8
);
    logic                   enable_i;
    logic                   hold_i;
    logic                   relock_en_i;
    logic signed [13:0]     err_i;
    logic signed [13:0]     ctrl_i;
    logic        [13:0]     lock_thr_i;
    logic        [CNTW-1:0] settle_len_i;
    logic        [CNTW-1:0] lost_len_i;
    logic signed [13:0]     sweep_min_i;
    logic signed [13:0]     sweep_max_i;
    logic        [13:0]     sweep_step_i;
    logic        [CNTW-1:0] sweep_div_i;

    logic                   int_rst_o;
    logic signed [13:0]     int_rst_val_o;
    logic                   pid_freeze_o;
    logic                   pid_ifreeze_o;
    logic                   locked_o;
    logic        [2:0]      state_o;
    logic        [RCW-1:0]  relock_cnt_o;

    modport master (
        output enable_i, hold_i, relock_en_i, err_i, ctrl_i, lock_thr_i,
               settle_len_i, lost_len_i, sweep_min_i, sweep_max_i,
               sweep_step_i, sweep_div_i,
        input  int_rst_o, int_rst_val_o, pid_freeze_o, pid_ifreeze_o,
               locked_o, state_o, relock_cnt_o
    );

    modport slave (
        input  enable_i, hold_i, relock_en_i, err_i, ctrl_i, lock_thr_i,
               settle_len_i, lost_len_i, sweep_min_i, sweep_max_i,
               sweep_step_i, sweep_div_i,
        output int_rst_o, int_rst_val_o, pid_freeze_o, pid_ifreeze_o,
               locked_o, state_o, relock_cnt_o
    );
endinterface

// File: rtl/lock_pid_sequencer.sv
// Lock-acquisition sequencer: triangle sweep of the integrator reset value,
// engage on window entry, declare lock after settling, re-sweep or fault on loss.
module lock_pid_sequencer #(
    parameter int CNTW   = 16,
    parameter int RCW    = 8,
    parameter int DATA_W = 14
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    lock_pid_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SWEEP  = 3'd1,
        S_ENGAGE = 3'd2,
        S_LOCKED = 3'd3,
        S_HOLD   = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    state_t                    state_q, state_d;
    logic signed [DATA_W-1:0]  sweep_val_q, sweep_val_d;
    logic                      dir_up_q, dir_up_d;
    logic        [CNTW-1:0]    pre_q, pre_d;
    logic        [CNTW-1:0]    in_q, in_d;
    logic        [CNTW-1:0]    out_q, out_d;
    logic        [RCW-1:0]     rc_q, rc_d;

    logic                      int_rst_q, int_rst_d;
    logic signed [DATA_W-1:0]  int_rst_val_q, int_rst_val_d;
    logic                      freeze_q, freeze_d;
    logic                      ifreeze_q, ifreeze_d;
    logic                      locked_q, locked_d;

    // Clamp a widened value into [lo, hi]; an inverted range pins to lo.
    function automatic logic signed [DATA_W-1:0] clamp_val(
        input logic signed [DATA_W+1:0] v,
        input logic signed [DATA_W-1:0] lo,
        input logic signed [DATA_W-1:0] hi
    );
        logic signed [DATA_W+1:0] lo_x;
        logic signed [DATA_W+1:0] hi_x;
        lo_x = (DATA_W+2)'(lo);
        hi_x = (DATA_W+2)'(hi);
        if (lo > hi)      return lo;
        else if (v > hi_x) return hi;
        else if (v < lo_x) return lo;
        else               return v[DATA_W-1:0];
    endfunction

    function automatic logic [CNTW-1:0] sat_inc_cnt(input logic [CNTW-1:0] c);
        return (&c) ? c : c + CNTW'(1);
    endfunction

    function automatic logic [RCW-1:0] sat_inc_rc(input logic [RCW-1:0] c);
        return (&c) ? c : c + RCW'(1);
    endfunction

    logic signed [DATA_W:0]    err_x;
    logic        [DATA_W:0]    abs_err;
    logic                      in_win;
    logic        [CNTW-1:0]    settle_eff, lost_eff;
    logic        [CNTW-1:0]    in_inc, out_inc;
    logic signed [DATA_W+1:0]  val_x, step_x;
    logic signed [DATA_W-1:0]  step_val;
    logic                      step_dir;
    logic signed [DATA_W-1:0]  ctrl_clamped;

    // Magnitude is taken one bit wider so the most negative error stays positive.
    always_comb begin
        err_x   = (DATA_W+1)'(bus.err_i);
        abs_err = err_x[DATA_W] ? (-err_x) : err_x;
        in_win  = (abs_err <= {1'b0, bus.lock_thr_i});
    end

    always_comb begin
        settle_eff   = (bus.settle_len_i == '0) ? CNTW'(1) : bus.settle_len_i;
        lost_eff     = (bus.lost_len_i   == '0) ? CNTW'(1) : bus.lost_len_i;
        in_inc       = sat_inc_cnt(in_q);
        out_inc      = sat_inc_cnt(out_q);
        val_x        = (DATA_W+2)'(sweep_val_q);
        step_x       = $signed({2'b00, bus.sweep_step_i});
        step_val     = clamp_val(dir_up_q ? (val_x + step_x) : (val_x - step_x),
                                 bus.sweep_min_i, bus.sweep_max_i);
        ctrl_clamped = clamp_val((DATA_W+2)'(bus.ctrl_i), bus.sweep_min_i, bus.sweep_max_i);
        if (step_val == bus.sweep_max_i)      step_dir = 1'b0;
        else if (step_val == bus.sweep_min_i) step_dir = 1'b1;
        else                                  step_dir = dir_up_q;
    end

    always_comb begin
        state_d     = state_q;
        sweep_val_d = sweep_val_q;
        dir_up_d    = dir_up_q;
        pre_d       = pre_q;
        in_d        = in_q;
        out_d       = out_q;
        rc_d        = rc_q;
        if (!bus.enable_i) begin
            state_d = S_IDLE;
            pre_d   = '0;
            in_d    = '0;
            out_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d     = S_SWEEP;
                    sweep_val_d = bus.sweep_min_i;
                    dir_up_d    = 1'b1;
                    pre_d       = '0;
                end
                S_SWEEP: begin
                    if (!bus.hold_i) begin
                        if (in_win) begin
                            state_d = S_ENGAGE;
                            pre_d   = '0;
                            in_d    = '0;
                            out_d   = '0;
                        end else if (pre_q >= bus.sweep_div_i) begin
                            pre_d       = '0;
                            sweep_val_d = step_val;
                            dir_up_d    = step_dir;
                        end else begin
                            pre_d = pre_q + CNTW'(1);
                        end
                    end
                end
                S_ENGAGE, S_LOCKED: begin
                    if (in_win) begin
                        in_d  = in_inc;
                        out_d = '0;
                    end else begin
                        in_d  = '0;
                        out_d = out_inc;
                    end
                    if (bus.hold_i) begin
                        state_d = S_HOLD;
                    end else if (state_q == S_ENGAGE && in_win && in_inc >= settle_eff) begin
                        state_d = S_LOCKED;
                        in_d    = '0;
                        out_d   = '0;
                    end else if (!in_win && out_inc >= lost_eff) begin
                        in_d  = '0;
                        out_d = '0;
                        pre_d = '0;
                        if (state_q == S_ENGAGE) begin
                            state_d = S_SWEEP;
                        end else if (bus.relock_en_i) begin
                            state_d     = S_SWEEP;
                            rc_d        = sat_inc_rc(rc_q);
                            sweep_val_d = ctrl_clamped;
                            dir_up_d    = 1'b1;
                        end else begin
                            state_d = S_FAULT;
                        end
                    end
                end
                S_HOLD: begin
                    if (!bus.hold_i) begin
                        state_d = S_ENGAGE;
                        in_d    = '0;
                        out_d   = '0;
                    end
                end
                S_FAULT: state_d = S_FAULT;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output decode from the next state keeps the registered outputs aligned with state_o.
    always_comb begin
        int_rst_d     = 1'b0;
        int_rst_val_d = sweep_val_d;
        freeze_d      = 1'b0;
        ifreeze_d     = 1'b0;
        locked_d      = 1'b0;
        case (state_d)
            S_IDLE: begin
                int_rst_d     = 1'b1;
                int_rst_val_d = bus.sweep_min_i;
                ifreeze_d     = 1'b1;
            end
            S_SWEEP: begin
                int_rst_d = 1'b1;
                ifreeze_d = 1'b1;
            end
            S_LOCKED: locked_d = 1'b1;
            S_HOLD: begin
                freeze_d  = 1'b1;
                ifreeze_d = 1'b1;
                locked_d  = locked_q;
            end
            S_FAULT: begin
                freeze_d  = 1'b1;
                ifreeze_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q       <= S_IDLE;
            sweep_val_q   <= '0;
            dir_up_q      <= 1'b1;
            pre_q         <= '0;
            in_q          <= '0;
            out_q         <= '0;
            rc_q          <= '0;
            int_rst_q     <= 1'b1;
            int_rst_val_q <= '0;
            freeze_q      <= 1'b0;
            ifreeze_q     <= 1'b1;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            sweep_val_q   <= sweep_val_d;
            dir_up_q      <= dir_up_d;
            pre_q         <= pre_d;
            in_q          <= in_d;
            out_q         <= out_d;
            rc_q          <= rc_d;
            int_rst_q     <= int_rst_d;
            int_rst_val_q <= int_rst_val_d;
            freeze_q      <= freeze_d;
            ifreeze_q     <= ifreeze_d;
            locked_q      <= locked_d;
        end
    end

    assign bus.state_o       = state_q;
    assign bus.int_rst_o     = int_rst_q;
    assign bus.int_rst_val_o = int_rst_val_q;
    assign bus.pid_freeze_o  = freeze_q;
    assign bus.pid_ifreeze_o = ifreeze_q;
    assign bus.locked_o      = locked_q;
    assign bus.relock_cnt_o  = rc_q;
endmodule

// File: tb/tb_lock_pid_sequencer.sv
// Scoreboard bench for lock_pid_sequencer: expected per-cycle outputs are queued
// with each stimulus and compared one time unit after the following clock edge.
module tb_lock_pid_sequencer;
    localparam int SKIP = -99999;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    lock_pid_sequencer_if #(.CNTW(16), .RCW(8)) sif ();

    lock_pid_sequencer #(.CNTW(16), .RCW(8)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (sif.slave)
    );

    typedef struct {
        string tag;
        int    st;
        int    ir;
        int    val;
        int    fz;
        int    ifz;
        int    lk;
        int    rc;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Queue the expectation for the next edge, advance, then drain the scoreboard.
    task automatic cycle(input string tag, input int st, input int ir, input int val,
                         input int fz, input int ifz, input int lk, input int rc);
        exp_t e;
        e = '{tag, st, ir, val, fz, ifz, lk, rc};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq({e.tag, ".state"},   int'(sif.state_o),       e.st);
            check_eq({e.tag, ".int_rst"}, int'(sif.int_rst_o),     e.ir);
            check_eq({e.tag, ".freeze"},  int'(sif.pid_freeze_o),  e.fz);
            check_eq({e.tag, ".ifreeze"}, int'(sif.pid_ifreeze_o), e.ifz);
            check_eq({e.tag, ".locked"},  int'(sif.locked_o),      e.lk);
            if (e.val != SKIP) check_eq({e.tag, ".val"}, int'(sif.int_rst_val_o), e.val);
            if (e.rc  != SKIP) check_eq({e.tag, ".relock_cnt"}, int'(sif.relock_cnt_o), e.rc);
        end
    endtask

    int v;
    int d;

    initial begin
        sif.enable_i     = 1'b0;
        sif.hold_i       = 1'b0;
        sif.relock_en_i  = 1'b1;
        sif.err_i        = 14'sd5000;
        sif.ctrl_i       = 14'sd1500;
        sif.lock_thr_i   = 14'd50;
        sif.settle_len_i = 16'd10;
        sif.lost_len_i   = 16'd4;
        sif.sweep_min_i  = -14'sd1000;
        sif.sweep_max_i  = 14'sd1000;
        sif.sweep_step_i = 14'd100;
        sif.sweep_div_i  = 16'd0;

        rstn = 1'b0;
        cycle("reset", 0, 1, 0, 0, 1, 0, 0);
        rstn = 1'b1;
        cycle("idle", 0, 1, -1000, 0, 1, 0, 0);

        // Triangle ramp with a flip at the upper bound
        sif.enable_i = 1'b1;
        cycle("sw_start", 1, 1, -1000, 0, 1, 0, SKIP);
        v = -1000;
        d = 100;
        for (int i = 0; i < 22; i++) begin
            v += d;
            if (v >= 1000) begin
                v = 1000;
                d = -100;
            end
            cycle("ramp", 1, 1, v, 0, 1, 0, SKIP);
        end
        sif.hold_i = 1'b1;
        cycle("sw_hold", 1, 1, 800, 0, 1, 0, SKIP);
        cycle("sw_hold", 1, 1, 800, 0, 1, 0, SKIP);
        sif.hold_i = 1'b0;

        // Engage, glitch restarts settle count
        sif.err_i = 14'sd20;
        cycle("engage", 2, 0, SKIP, 0, 0, 0, SKIP);
        for (int i = 0; i < 4; i++) cycle("settle_a", 2, 0, SKIP, 0, 0, 0, SKIP);
        sif.err_i = 14'sd5000;
        cycle("glitch", 2, 0, SKIP, 0, 0, 0, SKIP);
        sif.err_i = -14'sd20;
        for (int i = 0; i < 9; i++) cycle("settle_b", 2, 0, SKIP, 0, 0, 0, SKIP);
        cycle("locked", 3, 0, SKIP, 0, 0, 1, 0);

        // Lock loss with relock: ctrl clamped to max
        sif.err_i = 14'sd5000;
        for (int i = 0; i < 3; i++) cycle("lost_cnt", 3, 0, SKIP, 0, 0, 1, 0);
        cycle("relock", 1, 1, 1000, 0, 1, 0, 1);

        // Relock counter saturation, with zero lengths floored to one
        sif.settle_len_i = 16'd0;
        sif.lost_len_i   = 16'd0;
        for (int k = 2; k <= 257; k++) begin
            sif.err_i = 14'sd20;
            cycle("rl_eng", 2, 0, SKIP, 0, 0, 0, SKIP);
            cycle("rl_lock", 3, 0, SKIP, 0, 0, 1, SKIP);
            sif.err_i = 14'sd5000;
            cycle("rl_sweep", 1, 1, 1000, 0, 1, 0, (k > 255) ? 255 : k);
        end

        // Lock loss without relock -> FAULT until disabled
        sif.relock_en_i = 1'b0;
        sif.err_i = 14'sd20;
        cycle("f_eng", 2, 0, SKIP, 0, 0, 0, SKIP);
        cycle("f_lock", 3, 0, SKIP, 0, 0, 1, SKIP);
        sif.err_i = 14'sd5000;
        cycle("fault", 5, 0, SKIP, 1, 1, 0, 255);
        sif.err_i = 14'sd20;
        cycle("fault_stay", 5, 0, SKIP, 1, 1, 0, 255);
        sif.enable_i = 1'b0;
        cycle("f_idle", 0, 1, -1000, 0, 1, 0, 255);

        // HOLD from LOCKED, release, and hold winning over lock loss
        sif.enable_i = 1'b1;
        cycle("h_sweep", 1, 1, -1000, 0, 1, 0, SKIP);
        cycle("h_eng", 2, 0, SKIP, 0, 0, 0, SKIP);
        cycle("h_lock", 3, 0, SKIP, 0, 0, 1, SKIP);
        sif.hold_i = 1'b1;
        cycle("hold", 4, 0, SKIP, 1, 1, 1, SKIP);
        sif.err_i = 14'sd5000;
        cycle("hold_stay", 4, 0, SKIP, 1, 1, 1, SKIP);
        sif.hold_i = 1'b0;
        sif.err_i  = 14'sd20;
        cycle("unhold", 2, 0, SKIP, 0, 0, 0, SKIP);
        cycle("h_relock", 3, 0, SKIP, 0, 0, 1, SKIP);
        sif.hold_i = 1'b1;
        sif.err_i  = 14'sd5000;
        cycle("hold_vs_lost", 4, 0, SKIP, 1, 1, 1, SKIP);
        sif.hold_i = 1'b0;
        sif.err_i  = 14'sd20;
        cycle("unhold2", 2, 0, SKIP, 0, 0, 0, SKIP);

        // Window edges: |-8192| is 8192, threshold equality is inside
        sif.enable_i = 1'b0;
        cycle("w_idle", 0, 1, -1000, 0, 1, 0, SKIP);
        sif.enable_i   = 1'b1;
        sif.err_i      = -14'sd8192;
        sif.lock_thr_i = 14'd8191;
        cycle("w_sweep", 1, 1, -1000, 0, 1, 0, SKIP);
        cycle("w_out", 1, 1, -900, 0, 1, 0, SKIP);
        sif.lock_thr_i = 14'd8192;
        cycle("w_in_min", 2, 0, SKIP, 0, 0, 0, SKIP);
        sif.lock_thr_i = 14'd50;
        sif.err_i      = 14'sd51;
        cycle("w_resume", 1, 1, -900, 0, 1, 0, SKIP);
        sif.err_i = 14'sd50;
        cycle("w_edge", 2, 0, SKIP, 0, 0, 0, SKIP);
        sif.err_i = 14'sd5000;
        cycle("w_resume2", 1, 1, -900, 0, 1, 0, SKIP);

        // Reset mid-SWEEP, then an inverted sweep range
        rstn = 1'b0;
        cycle("mid_reset", 0, 1, 0, 0, 1, 0, 0);
        rstn = 1'b1;
        sif.sweep_min_i = 14'sd500;
        sif.sweep_max_i = -14'sd500;
        cycle("inv_sweep", 1, 1, 500, 0, 1, 0, 0);
        cycle("inv_hold", 1, 1, 500, 0, 1, 0, 0);
        cycle("inv_hold", 1, 1, 500, 0, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
